// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control-code type and named control constants
//                used by the ALU arbiter and its clients.
//  Contents    : alu_ctrl_t (4-bit ALUControl), ALU_* opcode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD  = 4'b0000;
    localparam alu_ctrl_t ALU_SUB  = 4'b1000;
    localparam alu_ctrl_t ALU_SLL  = 4'b0001;
    localparam alu_ctrl_t ALU_SLT  = 4'b0010;
    localparam alu_ctrl_t ALU_SLTU = 4'b0011;
    localparam alu_ctrl_t ALU_XOR  = 4'b0100;
    localparam alu_ctrl_t ALU_SRL  = 4'b0101;
    localparam alu_ctrl_t ALU_SRA  = 4'b1101;
    localparam alu_ctrl_t ALU_OR   = 4'b0110;
    localparam alu_ctrl_t ALU_AND  = 4'b0111;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the request
//                vector starting one position after the last-grant pointer
//                and returns the first requester found.
//  Ports       : req_i   - request vector
//                ptr_i   - index of the last granted requester
//                en_i    - grant enable; no grant when low
//                grant_o - one-hot grant
//                idx_o   - encoded index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int  N_REQ = 2,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o
);

    logic [ID_W-1:0] cand;
    logic            found;

    // Walk ptr+1 .. ptr+N_REQ (mod N_REQ); the last grantee is visited last,
    // which bounds the wait of a persistent requester to N_REQ-1 grants.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr_i) + k) % N_REQ);
            if (en_i && !found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one combinational ALU between N_REQ requesters.
//                Round-robin accept into an issue register (S1) that drives
//                the ALU, result captured into a response register (S2)
//                with valid/ready backpressure. Results leave in grant order.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                req_valid/req_ready           - per-requester handshake
//                req_ctrl/req_a/req_b          - per-requester operation
//                alu_ctrl/alu_a/alu_b          - to the ALU (from S1)
//                alu_result/alu_zero           - from the ALU
//                rsp_valid/rsp_ready           - response handshake
//                rsp_id/rsp_result/rsp_zero    - tagged response (from S2)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int  D_WIDTH = 32,
    parameter int  N_REQ   = 2,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  alu_ctrl_t [N_REQ-1:0]         req_ctrl,
    input  logic [N_REQ-1:0][D_WIDTH-1:0] req_a,
    input  logic [N_REQ-1:0][D_WIDTH-1:0] req_b,
    output alu_ctrl_t                     alu_ctrl,
    output logic [D_WIDTH-1:0]            alu_a,
    output logic [D_WIDTH-1:0]            alu_b,
    input  logic [D_WIDTH-1:0]            alu_result,
    input  logic                          alu_zero,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [D_WIDTH-1:0]            rsp_result,
    output logic                          rsp_zero
);

    // S1: issue register
    logic                s1_valid_q;
    alu_ctrl_t           s1_ctrl_q;
    logic [D_WIDTH-1:0]  s1_a_q;
    logic [D_WIDTH-1:0]  s1_b_q;
    logic [ID_W-1:0]     s1_id_q;

    // S2: response register
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [D_WIDTH-1:0]  rsp_result_q;
    logic                rsp_zero_q;

    // Last-grant pointer
    logic [ID_W-1:0]     ptr_q;

    logic                s2_free;
    logic                s1_adv;
    logic                accept_en;
    logic                arb_en;
    logic                hs;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     gnt_idx;

    assign s2_free   = !rsp_valid_q || rsp_ready;
    assign s1_adv    = s1_valid_q && s2_free;
    // S1 can take a new op when empty or when its current op moves to S2
    // this same cycle.
    assign accept_en = !s1_valid_q || s1_adv;
    assign arb_en    = accept_en && !rst;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (grant),
        .idx_o   (gnt_idx)
    );

    // The arbiter only grants valid requesters, so any grant is a handshake.
    assign req_ready = grant;
    assign hs        = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_ctrl_q    <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            ptr_q        <= ID_W'(N_REQ - 1);
        end else begin
            if (s1_adv) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= s1_id_q;
                rsp_result_q <= alu_result;
                rsp_zero_q   <= alu_zero;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q  <= 1'b0;
            end

            if (hs) begin
                s1_valid_q <= 1'b1;
                s1_ctrl_q  <= req_ctrl[gnt_idx];
                s1_a_q     <= req_a[gnt_idx];
                s1_b_q     <= req_b[gnt_idx];
                s1_id_q    <= gnt_idx;
                ptr_q      <= gnt_idx;
            end else if (s1_adv) begin
                // Payload is left in place so the ALU inputs hold steady.
                s1_valid_q <= 1'b0;
            end
        end
    end

    assign alu_ctrl   = s1_ctrl_q;
    assign alu_a      = s1_a_q;
    assign alu_b      = s1_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. A 2-requester and a
//                4-requester instance each sit beside a behavioural ALU.
//                Handshakes push expected responses into a scoreboard queue;
//                a monitor pops and compares on every response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DEPTH = 256;

    typedef struct packed {
        alu_ctrl_t   c;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- 2-requester instance ----------------
    logic [1:0]        v2, rdy2;
    alu_ctrl_t [1:0]   c2;
    logic [1:0][31:0]  a2, b2;
    alu_ctrl_t         actl2;
    logic [31:0]       aa2, ab2, ares2, rres2;
    logic              az2, rv2, rrdy2, rz2;
    logic [0:0]        rid2;

    // ---------------- 4-requester instance ----------------
    logic [3:0]        v4, rdy4;
    alu_ctrl_t [3:0]   c4;
    logic [3:0][31:0]  a4, b4;
    alu_ctrl_t         actl4;
    logic [31:0]       aa4, ab4, ares4, rres4;
    logic              az4, rv4, rrdy4, rz4;
    logic [1:0]        rid4;

    // Reference ALU (RISC-V style semantics for the named codes)
    function automatic logic [31:0] alu_f(alu_ctrl_t c, logic [31:0] a, logic [31:0] b);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    always_comb begin
        ares2 = alu_f(actl2, aa2, ab2);
        az2   = (ares2 == 32'd0);
        ares4 = alu_f(actl4, aa4, ab4);
        az4   = (ares4 == 32'd0);
    end

    alu_arbiter #(.D_WIDTH(32), .N_REQ(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(v2), .req_ready(rdy2), .req_ctrl(c2), .req_a(a2), .req_b(b2),
        .alu_ctrl(actl2), .alu_a(aa2), .alu_b(ab2), .alu_result(ares2), .alu_zero(az2),
        .rsp_valid(rv2), .rsp_ready(rrdy2), .rsp_id(rid2), .rsp_result(rres2), .rsp_zero(rz2)
    );

    alu_arbiter #(.D_WIDTH(32), .N_REQ(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(v4), .req_ready(rdy4), .req_ctrl(c4), .req_a(a4), .req_b(b4),
        .alu_ctrl(actl4), .alu_a(aa4), .alu_b(ab4), .alu_result(ares4), .alu_zero(az4),
        .rsp_valid(rv4), .rsp_ready(rrdy4), .rsp_id(rid4), .rsp_result(rres4), .rsp_zero(rz4)
    );

    // ---------------- scoreboard state ----------------
    int npass = 0;
    int ntot  = 0;

    exp_t q2[$], q4[$];
    exp_t rlog2[$];
    int   glog2[$], glog4[$], gc4[$];
    int   ptr2 = 1, ptr4 = 3;          // reference last-grant pointers
    logic [1:0] lr2 = '0;
    logic [3:0] lr4 = '0;
    exp_t e;
    int   gi;

    // Per-requester stimulus slots: 0..1 -> dut2, 2..5 -> dut4
    op_t  ops [6][DEPTH];
    int   hd [6] = '{default: 0};
    int   tl [6] = '{default: 0};

    alu_ctrl_t codes [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (ok) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Round-robin reference: first valid requester after the last grant.
    function automatic int rr_pick(int ptr, logic [3:0] v, int n);
        for (int k = 1; k <= n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic enq(input int s, input alu_ctrl_t c, input logic [31:0] a, input logic [31:0] b);
        if (tl[s] < DEPTH) begin
            ops[s][tl[s]] = '{c: c, a: a, b: b};
            tl[s]++;
        end
    endtask

    task automatic enq_rand(input int s);
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        enq(s, codes[$urandom_range(0, 9)], a, b);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit idle2();
        return (q2.size() == 0) && (v2 == 2'b00) && (hd[0] == tl[0]) && (hd[1] == tl[1]);
    endfunction

    // ---------------- requester driver ----------------
    initial begin
        v2 = '0; c2 = '0; a2 = '0; b2 = '0;
        v4 = '0; c4 = '0; a4 = '0; b4 = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (v2[i] && lr2[i]) v2[i] = 1'b0;
                if (!v2[i] && hd[i] < tl[i]) begin
                    c2[i] = ops[i][hd[i]].c;
                    a2[i] = ops[i][hd[i]].a;
                    b2[i] = ops[i][hd[i]].b;
                    hd[i]++;
                    v2[i] = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (v4[i] && lr4[i]) v4[i] = 1'b0;
                if (!v4[i] && hd[i+2] < tl[i+2]) begin
                    c4[i] = ops[i+2][hd[i+2]].c;
                    a4[i] = ops[i+2][hd[i+2]].a;
                    b4[i] = ops[i+2][hd[i+2]].b;
                    hd[i+2]++;
                    v4[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk((rdy2 == 2'b00) && (rdy4 == 4'b0000), "rst_req_ready", {rdy4, rdy2}, 64'd0);
            q2.delete();
            q4.delete();
            ptr2 = 1;
            ptr4 = 3;
            lr2  = '0;
            lr4  = '0;
        end else begin
            if (rv2 && rrdy2) begin
                if (q2.size() == 0) begin
                    chk(1'b0, "rsp2_unexpected", rres2, 64'd0);
                end else begin
                    e = q2.pop_front();
                    chk(rid2 == e.id[0:0], "rsp2_id", rid2, e.id);
                    chk(rres2 == e.res, "rsp2_result", rres2, e.res);
                    chk(rz2 == e.z, "rsp2_zero", rz2, e.z);
                end
                e.id = rid2; e.res = rres2; e.z = rz2; e.cyc = cyc;
                rlog2.push_back(e);
            end
            if (|rdy2) begin
                gi = 0;
                for (int i = 1; i >= 0; i--) if (rdy2[i]) gi = i;
                chk(($countones(rdy2) == 1) && ((rdy2 & ~v2) == 2'b00), "grant2_onehot", rdy2, v2);
                chk(gi == rr_pick(ptr2, {2'b00, v2}, 2), "grant2_rr", gi, rr_pick(ptr2, {2'b00, v2}, 2));
                e.id = gi; e.res = alu_f(c2[gi], a2[gi], b2[gi]); e.z = (e.res == 32'd0); e.cyc = cyc;
                q2.push_back(e);
                ptr2 = gi;
                glog2.push_back(gi);
            end
            lr2 = rdy2;

            if (rv4 && rrdy4) begin
                if (q4.size() == 0) begin
                    chk(1'b0, "rsp4_unexpected", rres4, 64'd0);
                end else begin
                    e = q4.pop_front();
                    chk(rid4 == e.id[1:0], "rsp4_id", rid4, e.id);
                    chk(rres4 == e.res, "rsp4_result", rres4, e.res);
                    chk(rz4 == e.z, "rsp4_zero", rz4, e.z);
                end
            end
            if (|rdy4) begin
                gi = 0;
                for (int i = 3; i >= 0; i--) if (rdy4[i]) gi = i;
                chk(($countones(rdy4) == 1) && ((rdy4 & ~v4) == 4'b0000), "grant4_onehot", rdy4, v4);
                chk(gi == rr_pick(ptr4, v4, 4), "grant4_rr", gi, rr_pick(ptr4, v4, 4));
                e.id = gi; e.res = alu_f(c4[gi], a4[gi], b4[gi]); e.z = (e.res == 32'd0); e.cyc = cyc;
                q4.push_back(e);
                ptr4 = gi;
                glog4.push_back(gi);
                gc4.push_back(cyc);
            end
            lr4 = rdy4;
        end
    end

    // ---------------- test sequence ----------------
    int          exp_g4 [10] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
    int          exp_g2 [4]  = '{0, 1, 0, 1};
    bit          seen;
    logic [0:0]  s_id;
    logic [31:0] s_res, s_a, s_b;
    logic        s_z;
    alu_ctrl_t   s_c;

    initial begin
        rst   = 1'b1;
        rrdy2 = 1'b1;
        rrdy4 = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk(rv2 == 1'b0 && rv4 == 1'b0, "reset_rsp_valid", {rv4, rv2}, 64'd0);
        chk(actl2 == 4'd0 && actl4 == 4'd0, "reset_alu_ctrl", {actl4, actl2}, 64'd0);
        chk(aa2 == 32'd0 && ab2 == 32'd0, "reset_alu_ab", {aa2, ab2}, 64'd0);
        chk(rid2 == 1'b0 && rres2 == 32'd0 && rz2 == 1'b0, "reset_rsp_fields", rres2, 64'd0);
        tick();
        rst = 1'b0;

        // N_REQ=4: all four requesting, then requester 2 drops out
        for (int k = 0; k < 3; k++) begin
            enq_rand(2); enq_rand(3); enq_rand(5);
            if (k == 0) enq_rand(4);
        end
        for (int k = 0; k < 60 && glog4.size() < 10; k++) @(negedge clk);
        chk(glog4.size() >= 10, "g4_count", glog4.size(), 10);
        if (glog4.size() >= 10) begin
            for (int k = 0; k < 10; k++) begin
                chk(glog4[k] == exp_g4[k], $sformatf("g4_order[%0d]", k), glog4[k], exp_g4[k]);
                chk(gc4[k] == gc4[0] + k, $sformatf("g4_no_stall[%0d]", k), gc4[k] - gc4[0], k);
            end
        end

        // Single op ADD 5+7 on requester 0, latency
        tick();
        enq(0, ALU_ADD, 32'd5, 32'd7);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = v2[0] && rdy2[0];
        end
        chk(seen, "single_handshake", seen, 1);
        @(negedge clk);
        @(negedge clk);
        chk(rv2 == 1'b1, "single_latency", rv2, 1);
        chk(rid2 == 1'b0 && rres2 == 32'd12 && rz2 == 1'b0, "single_value", {rid2, rres2, rz2}, {1'b0, 32'd12, 1'b0});

        // Reset, then both requesters continuously
        tick();
        rst = 1'b1;
        tick();
        glog2.delete();
        rlog2.delete();
        rst = 1'b0;
        enq(0, ALU_SUB, 32'd9, 32'd9);
        enq(0, ALU_AND, 32'hFF, 32'h0F);
        enq(1, ALU_SRA, 32'h8000_0000, 32'd4);
        enq(1, ALU_OR, 32'd1, 32'd2);
        for (int k = 0; k < 40 && rlog2.size() < 4; k++) @(negedge clk);
        chk(glog2.size() >= 4 && rlog2.size() >= 2, "both_count", glog2.size(), 4);
        if (glog2.size() >= 4 && rlog2.size() >= 2) begin
            for (int k = 0; k < 4; k++)
                chk(glog2[k] == exp_g2[k], $sformatf("g2_order[%0d]", k), glog2[k], exp_g2[k]);
            chk(rlog2[0].id == 0 && rlog2[0].res == 32'd0 && rlog2[0].z == 1'b1, "sub_zero",
                {rlog2[0].id[0], rlog2[0].res, rlog2[0].z}, {1'b0, 32'd0, 1'b1});
            chk(rlog2[1].id == 1 && rlog2[1].res == 32'hF800_0000 && rlog2[1].z == 1'b0, "sra_neg",
                {rlog2[1].id[0], rlog2[1].res, rlog2[1].z}, {1'b1, 32'hF800_0000, 1'b0});
        end

        // Backpressure: fill S1 and S2 then hold rsp_ready low
        for (int k = 0; k < 40 && !idle2(); k++) @(negedge clk);
        tick();
        rlog2.delete();
        rrdy2 = 1'b0;
        enq(0, ALU_ADD, 32'd100, 32'd1);
        enq(1, ALU_SUB, 32'd50, 32'd8);
        enq(0, ALU_SLL, 32'd1, 32'd31);
        repeat (5) tick();
        @(negedge clk);
        chk(rv2 == 1'b1, "bp_full", rv2, 1);
        s_id = rid2; s_res = rres2; s_z = rz2; s_c = actl2; s_a = aa2; s_b = ab2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(rdy2 == 2'b00, "bp_ready_low", rdy2, 0);
            chk(rv2 && rid2 == s_id && rres2 == s_res && rz2 == s_z, "bp_rsp_hold", rres2, s_res);
            chk(actl2 == s_c && aa2 == s_a && ab2 == s_b, "bp_alu_hold", aa2, s_a);
        end
        tick();
        rrdy2 = 1'b1;
        for (int k = 0; k < 20 && rlog2.size() < 2; k++) @(negedge clk);
        chk(rlog2.size() >= 2, "bp_drain_count", rlog2.size(), 2);
        if (rlog2.size() >= 2) begin
            chk(rlog2[0].id == 0 && rlog2[0].res == 32'd101, "bp_first", rlog2[0].res, 101);
            chk(rlog2[1].id == 1 && rlog2[1].res == 32'd42, "bp_second", rlog2[1].res, 42);
            chk(rlog2[1].cyc == rlog2[0].cyc + 1, "bp_consecutive", rlog2[1].cyc - rlog2[0].cyc, 1);
        end

        // Throughput: requester 1 alone, 8 back-to-back
        for (int k = 0; k < 40 && !idle2(); k++) @(negedge clk);
        tick();
        rlog2.delete();
        for (int k = 0; k < 8; k++) enq_rand(1);
        for (int k = 0; k < 40 && rlog2.size() < 8; k++) @(negedge clk);
        chk(rlog2.size() >= 8, "tput_count", rlog2.size(), 8);
        if (rlog2.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk(rlog2[k].id == 1, $sformatf("tput_id[%0d]", k), rlog2[k].id, 1);
                chk(rlog2[k].cyc == rlog2[0].cyc + k, $sformatf("tput_cycle[%0d]", k), rlog2[k].cyc - rlog2[0].cyc, k);
            end
        end

        // Reset mid-operation with S1 and S2 full
        for (int k = 0; k < 40 && !idle2(); k++) @(negedge clk);
        tick();
        rrdy2 = 1'b0;
        for (int k = 0; k < 3; k++) begin enq_rand(0); enq_rand(1); end
        repeat (5) tick();
        @(negedge clk);
        chk(rv2 == 1'b1 && rdy2 == 2'b00, "mid_pre_full", {rv2, rdy2}, 3'b100);
        tick();
        rst = 1'b1;
        glog2.delete();
        @(posedge clk);
        @(negedge clk);
        chk(rv2 == 1'b0, "mid_rsp_valid", rv2, 0);
        chk(actl2 == 4'd0 && aa2 == 32'd0 && ab2 == 32'd0, "mid_alu_zero", aa2, 0);
        tick();
        rst   = 1'b0;
        rrdy2 = 1'b1;
        for (int k = 0; k < 20 && glog2.size() < 1; k++) @(negedge clk);
        chk(glog2.size() >= 1 && glog2[0] == 0, "mid_first_grant", (glog2.size() > 0) ? glog2[0] : -1, 0);

        // Randomised traffic with random backpressure
        for (int k = 0; k < 300; k++) begin
            tick();
            for (int s = 0; s < 2; s++)
                if (tl[s] - hd[s] < 2 && $urandom_range(0, 1) == 1) enq_rand(s);
            rrdy2 = ($urandom_range(0, 3) != 0);
        end
        tick();
        rrdy2 = 1'b1;
        for (int k = 0; k < 200 && !(idle2() && !rv2); k++) @(negedge clk);
        chk(idle2() && !rv2, "drain_empty", q2.size(), 0);
        chk(q4.size() == 0, "drain4_empty", q4.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", npass, ntot);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
